// File: rtl/ram_shim.sv
// Streams raster samples into a memory ring buffer, one bus write per commit, four-phase handshake.
// Latency: mem_we one cycle after commit, finished one cycle after mem_ack.
// Backpressure: stalls in WAIT_SPACE while the ring is full (sticky overflow), holds the request until mem_ack.
module ram_shim #(
    parameter int DAT_WID  = 24,
    parameter int BUS_WID  = 32,
    parameter int ADDR_WID = 32,
    parameter int PTR_WID  = 16
) (
    input  logic                clk,
    input  logic                rst_L,
    input  logic [DAT_WID-1:0]  data,
    input  logic                commit,
    output logic                finished,
    input  logic [ADDR_WID-1:0] base_addr_in,
    input  logic [PTR_WID-1:0]  buf_words_in,
    input  logic                clear,
    input  logic [PTR_WID-1:0]  rd_ptr,
    output logic [PTR_WID-1:0]  wr_ptr,
    output logic                full,
    output logic                overflow,
    output logic [ADDR_WID-1:0] mem_addr,
    output logic [BUS_WID-1:0]  mem_wdata,
    output logic                mem_we,
    input  logic                mem_ack
);

    localparam int BYTES = BUS_WID / 8;

    typedef enum logic [1:0] {IDLE, WAIT_SPACE, WRITE, HANDSHAKE} state_t;

    state_t              state;
    logic [ADDR_WID-1:0] base_q;
    logic [PTR_WID-1:0]  buf_words_q;
    logic                clr_pend;
    logic [PTR_WID-1:0]  wr_ptr_inc;
    logic [ADDR_WID-1:0] slot_addr;
    logic [BUS_WID-1:0]  data_sx;

    assign wr_ptr_inc = (wr_ptr == buf_words_q - PTR_WID'(1)) ? '0 : wr_ptr + PTR_WID'(1);
    assign full       = (wr_ptr_inc == rd_ptr);
    assign slot_addr  = base_q + ADDR_WID'(wr_ptr) * ADDR_WID'(BYTES);
    assign data_sx    = BUS_WID'($signed(data));

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            finished    <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            overflow    <= 1'b0;
            clr_pend    <= 1'b0;
            base_q      <= '0;
            buf_words_q <= '0;
        end else begin
            // A clear seen mid-transaction is parked until the ring is idle again.
            if (clear && state != IDLE)
                clr_pend <= 1'b1;
            case (state)
                IDLE: begin
                    if (clear) begin
                        wr_ptr      <= '0;
                        overflow    <= 1'b0;
                        base_q      <= base_addr_in;
                        buf_words_q <= buf_words_in;
                        clr_pend    <= 1'b0;
                    end else if (commit) begin
                        mem_wdata <= data_sx;
                        if (full) begin
                            state    <= WAIT_SPACE;
                            overflow <= 1'b1;
                        end else begin
                            state    <= WRITE;
                            mem_we   <= 1'b1;
                            mem_addr <= slot_addr;
                        end
                    end
                end
                WAIT_SPACE: begin
                    if (!full) begin
                        state    <= WRITE;
                        mem_we   <= 1'b1;
                        mem_addr <= slot_addr;
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        state    <= HANDSHAKE;
                        mem_we   <= 1'b0;
                        wr_ptr   <= wr_ptr_inc;
                        finished <= 1'b1;
                    end
                end
                HANDSHAKE: begin
                    if (!commit) begin
                        state    <= IDLE;
                        finished <= 1'b0;
                        if (clear || clr_pend) begin
                            wr_ptr      <= '0;
                            overflow    <= 1'b0;
                            base_q      <= base_addr_in;
                            buf_words_q <= buf_words_in;
                            clr_pend    <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_shim.sv
// Directed bench for ram_shim: scoreboard of expected bus writes checked at each acknowledged beat.
module tb_ram_shim;

    localparam int DAT_WID  = 24;
    localparam int BUS_WID  = 32;
    localparam int ADDR_WID = 32;
    localparam int PTR_WID  = 16;

    logic                clk;
    logic                rst_L;
    logic [DAT_WID-1:0]  data;
    logic                commit;
    logic                finished;
    logic [ADDR_WID-1:0] base_addr_in;
    logic [PTR_WID-1:0]  buf_words_in;
    logic                clear;
    logic [PTR_WID-1:0]  rd_ptr;
    logic [PTR_WID-1:0]  wr_ptr;
    logic                full;
    logic                overflow;
    logic [ADDR_WID-1:0] mem_addr;
    logic [BUS_WID-1:0]  mem_wdata;
    logic                mem_we;
    logic                mem_ack;

    ram_shim #(
        .DAT_WID(DAT_WID), .BUS_WID(BUS_WID), .ADDR_WID(ADDR_WID), .PTR_WID(PTR_WID)
    ) dut (
        .clk(clk), .rst_L(rst_L), .data(data), .commit(commit), .finished(finished),
        .base_addr_in(base_addr_in), .buf_words_in(buf_words_in), .clear(clear),
        .rd_ptr(rd_ptr), .wr_ptr(wr_ptr), .full(full), .overflow(overflow),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_ack(mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_WID-1:0] addr;
        logic [BUS_WID-1:0]  wdata;
    } txn_t;

    txn_t sb[$];
    int   tests    = 0;
    int   fails    = 0;
    int   n_writes = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BUS_WID-1:0] sext(input logic [DAT_WID-1:0] d);
        return {{(BUS_WID-DAT_WID){d[DAT_WID-1]}}, d};
    endfunction

    task automatic expect_write(input logic [ADDR_WID-1:0] a, input logic [DAT_WID-1:0] d);
        txn_t t;
        t.addr  = a;
        t.wdata = sext(d);
        sb.push_back(t);
    endtask

    // Acknowledged beats are compared against the oldest expected write.
    always @(negedge clk) begin
        if (rst_L && mem_we && mem_ack) begin
            txn_t t;
            n_writes++;
            chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                t = sb.pop_front();
                chk("bus_addr", 64'(mem_addr), 64'(t.addr));
                chk("bus_wdata", 64'(mem_wdata), 64'(t.wdata));
            end
        end
    end

    // Commit, check the request one cycle later, ack after ack_dly cycles; commit left high.
    task automatic do_write(input logic [DAT_WID-1:0] d, input logic [ADDR_WID-1:0] a, input int ack_dly);
        data   = d;
        commit = 1'b1;
        expect_write(a, d);
        tick();
        chk("we_latency", 64'(mem_we), 64'd1);
        chk("req_addr", 64'(mem_addr), 64'(a));
        for (int i = 0; i < ack_dly; i++) begin
            tick();
            chk("we_held", 64'(mem_we), 64'd1);
        end
        chk("fin_before_ack", 64'(finished), 64'd0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("fin_after_ack", 64'(finished), 64'd1);
        chk("we_drop", 64'(mem_we), 64'd0);
    endtask

    task automatic release_commit();
        commit = 1'b0;
        tick();
        chk("fin_release", 64'(finished), 64'd0);
    endtask

    task automatic do_clear(input logic [ADDR_WID-1:0] b, input logic [PTR_WID-1:0] n);
        base_addr_in = b;
        buf_words_in = n;
        clear        = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear_ptr", 64'(wr_ptr), 64'd0);
    endtask

    initial begin
        int w0;
        int we_seen;
        rst_L = 1'b0; data = '0; commit = 1'b0; base_addr_in = '0; buf_words_in = '0;
        clear = 1'b0; rd_ptr = '0; mem_ack = 1'b0;

        // Reset values before any clock edge.
        #2;
        chk("rst_finished", 64'(finished), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_wr_ptr", 64'(wr_ptr), 64'd0);
        tick(); tick();
        rst_L = 1'b1;
        tick();

        // Basic write with sign extension and two-cycle ack.
        do_clear(32'h1000, 16'd8);
        do_write(24'h800001, 32'h1000, 2);
        chk("wdata_sext", 64'(mem_wdata), 64'hFF80_0001);
        tick(); tick();
        chk("fin_hold", 64'(finished), 64'd1);
        release_commit();
        chk("ptr_after_1", 64'(wr_ptr), 64'd1);

        // Ring of 4: fill, stall on full, release by moving rd_ptr, wrap.
        do_clear(32'h2000, 16'd4);
        rd_ptr = '0;
        do_write(24'h123456, 32'h2000, 0); release_commit();
        do_write(24'h7FFFFF, 32'h2004, 1); release_commit();
        chk("full_at_2", 64'(full), 64'd0);
        do_write(24'hFEDCBA, 32'h2008, 0); release_commit();
        chk("full_at_3", 64'(full), 64'd1);
        chk("ovf_before_stall", 64'(overflow), 64'd0);
        data   = 24'hABCDEF;
        commit = 1'b1;
        expect_write(32'h200C, 24'hABCDEF);
        tick();
        chk("stall_we", 64'(mem_we), 64'd0);
        chk("stall_ovf", 64'(overflow), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_we_hold", 64'(mem_we), 64'd0);
        end
        rd_ptr = 16'd1;
        tick();
        chk("unstall_we", 64'(mem_we), 64'd1);
        chk("unstall_addr", 64'(mem_addr), 64'h200C);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("unstall_fin", 64'(finished), 64'd1);
        chk("ptr_wrap", 64'(wr_ptr), 64'd0);
        chk("full_after_wrap", 64'(full), 64'd1);
        release_commit();
        chk("ovf_sticky", 64'(overflow), 64'd1);
        rd_ptr = '0;
        #1;
        chk("full_cleared", 64'(full), 64'd0);

        // Commit held high long after finished: only one transaction.
        w0 = n_writes;
        we_seen = 0;
        do_write(24'h000042, 32'h2000, 1);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mem_we) we_seen++;
        end
        chk("hold_fin", 64'(finished), 64'd1);
        chk("hold_no_we", 64'(we_seen), 64'd0);
        chk("hold_one_txn", 64'(n_writes - w0), 64'd1);
        release_commit();

        // Clear pulsed during WRITE is deferred until IDLE.
        data   = 24'h0F0F0F;
        commit = 1'b1;
        expect_write(32'h2004, 24'h0F0F0F);
        tick();
        chk("cw_we", 64'(mem_we), 64'd1);
        base_addr_in = 32'h3000;
        buf_words_in = 16'd8;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("cw_addr_old", 64'(mem_addr), 64'h2004);
        chk("cw_ptr_kept", 64'(wr_ptr), 64'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("cw_fin", 64'(finished), 64'd1);
        chk("cw_ptr_inc", 64'(wr_ptr), 64'd2);
        release_commit();
        chk("cw_ptr_cleared", 64'(wr_ptr), 64'd0);
        chk("cw_ovf_cleared", 64'(overflow), 64'd0);
        do_write(24'h111111, 32'h3000, 0);
        release_commit();

        // Stray ack while idle does nothing.
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("stray_ack_ptr", 64'(wr_ptr), 64'd1);
        chk("stray_ack_we", 64'(mem_we), 64'd0);
        chk("stray_ack_fin", 64'(finished), 64'd0);

        // Clear and commit together: clear first, write at base+0 next cycle.
        base_addr_in = 32'h4000;
        clear  = 1'b1;
        commit = 1'b1;
        data   = 24'h222222;
        tick();
        clear = 1'b0;
        chk("cc_ptr", 64'(wr_ptr), 64'd0);
        chk("cc_we", 64'(mem_we), 64'd0);
        do_write(24'h222222, 32'h4000, 1);
        release_commit();

        // Reset while a request waits for an ack that never comes.
        data   = 24'h333333;
        commit = 1'b1;
        expect_write(32'h4004, 24'h333333);
        tick();
        chk("rw_we", 64'(mem_we), 64'd1);
        tick(); tick();
        rst_L = 1'b0;
        #1;
        chk("rw_we_drop", 64'(mem_we), 64'd0);
        chk("rw_fin", 64'(finished), 64'd0);
        chk("rw_addr", 64'(mem_addr), 64'd0);
        chk("rw_ptr", 64'(wr_ptr), 64'd0);
        sb.delete();
        commit = 1'b0;
        tick();
        rst_L = 1'b1;
        tick(); tick();
        chk("rw_post_we", 64'(mem_we), 64'd0);
        chk("rw_post_ptr", 64'(wr_ptr), 64'd0);
        do_clear(32'h5000, 16'd8);
        do_write(24'h444444, 32'h5000, 0);
        release_commit();
        chk("rw_post_ptr1", 64'(wr_ptr), 64'd1);

        tick();
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
